// File: rtl/gbc_bus_initiator.sv
// Wishbone B4 pipelined initiator for the 16-bit address / 8-bit data GB bus.
// Command stream in, in-order buffered responses out, with a hung-target timeout.
module gbc_bus_initiator #(
    parameter int         MaxOutstanding = 2,
    parameter int         TimeoutCycles  = 1024,
    parameter logic [7:0] TimeoutData    = 8'hFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic        CmdWrite,
    input  logic [15:0] CmdAddr,
    input  logic [7:0]  CmdData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [7:0]  RspData,
    output logic        RspErr,
    output logic        Timeout,
    output logic        CYC,
    output logic        STB,
    output logic        WE,
    output logic [15:0] ADR,
    output logic [7:0]  DAT_O,
    input  logic [7:0]  DAT_I,
    input  logic        ACK,
    input  logic        ERR,
    input  logic        STALL
);

    localparam int OW = $clog2(MaxOutstanding + 1);
    localparam int PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int TW = $clog2(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } state_t;

    state_t        state_q, state_d;
    logic          stb_q, stb_d;
    logic          we_q;
    logic [15:0]   adr_q;
    logic [7:0]    dat_q;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] cred_q;
    logic [OW-1:0] abt_q, abt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_pls_q;

    logic [8:0]    mem [MaxOutstanding];
    logic [PW-1:0] wp_q, rp_q;
    logic [OW-1:0] cnt_q;

    logic          cmd_acc, stb_acc, rsp_ev, pop, tmo_hit;
    logic          push, push_err;
    logic [7:0]    push_dat;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
    endfunction

    assign CmdReady = ~RST & (state_q != ABORT)
                    & (cred_q < OW'(MaxOutstanding))
                    & (~stb_q | ~STALL);
    assign cmd_acc  = CmdValid & CmdReady;
    assign stb_acc  = stb_q & ~STALL;
    assign rsp_ev   = (state_q == BUSY) & (ACK | ERR) & (out_q != '0);
    assign pop      = RspValid & RspReady;
    assign tmo_hit  = (state_q == BUSY) & ~stb_acc & ~rsp_ev
                    & (tmo_q == TW'(TimeoutCycles - 1));

    assign CYC      = (state_q == BUSY);
    assign STB      = stb_q;
    assign WE       = we_q;
    assign ADR      = adr_q;
    assign DAT_O    = dat_q;
    assign Timeout  = tmo_pls_q;
    assign RspValid = (cnt_q != '0);
    assign RspData  = mem[rp_q][8:1];
    assign RspErr   = mem[rp_q][0];

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        out_d    = out_q;
        abt_d    = abt_q;
        tmo_d    = tmo_q;
        push     = 1'b0;
        push_err = 1'b0;
        push_dat = DAT_I;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (cmd_acc) begin
                    state_d = BUSY;
                    stb_d   = 1'b1;
                end
            end
            BUSY: begin
                if (cmd_acc)      stb_d = 1'b1;
                else if (stb_acc) stb_d = 1'b0;
                out_d    = out_q + OW'(stb_acc) - OW'(rsp_ev);
                push     = rsp_ev;
                push_err = ERR;
                if (tmo_hit) begin
                    // a command taken on this edge counts as a pending strobe
                    state_d = ABORT;
                    stb_d   = 1'b0;
                    out_d   = '0;
                    abt_d   = out_q + OW'(stb_q | cmd_acc);
                    tmo_d   = '0;
                end else begin
                    tmo_d = (stb_acc | rsp_ev) ? '0 : tmo_q + TW'(1);
                    if (!stb_d && out_d == '0) state_d = IDLE;
                end
            end
            ABORT: begin
                push     = (abt_q != '0);
                push_err = 1'b1;
                push_dat = TimeoutData;
                if (abt_q != '0) abt_d = abt_q - OW'(1);
                if (abt_q <= OW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            out_q     <= '0;
            cred_q    <= '0;
            abt_q     <= '0;
            tmo_q     <= '0;
            tmo_pls_q <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            stb_q     <= stb_d;
            out_q     <= out_d;
            abt_q     <= abt_d;
            tmo_q     <= tmo_d;
            tmo_pls_q <= tmo_hit;
            cred_q    <= cred_q + OW'(cmd_acc) - OW'(pop);
            cnt_q     <= cnt_q + OW'(push) - OW'(pop);
            if (cmd_acc) begin
                we_q  <= CmdWrite;
                adr_q <= CmdAddr;
                dat_q <= CmdData;
            end
            if (push) wp_q <= nxt(wp_q);
            if (pop)  rp_q <= nxt(rp_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wp_q] <= {push_dat, push_err};
    end

endmodule

// File: tb/tb_gbc_bus_initiator.sv
// Directed bench for gbc_bus_initiator: reads, writes, stall, error,
// timeout abort and mid-transfer reset, with hand-computed expectations.
module tb_gbc_bus_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  rsp_data;
    logic        tmo;
    logic        cyc, stb, we;
    logic [15:0] adr;
    logic [7:0]  dat_o, dat_i;
    logic        ack, err, stall;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gbc_bus_initiator #(
        .MaxOutstanding(2),
        .TimeoutCycles (16),
        .TimeoutData   (8'hFF)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .CmdValid(cmd_valid),
        .CmdReady(cmd_ready),
        .CmdWrite(cmd_write),
        .CmdAddr (cmd_addr),
        .CmdData (cmd_data),
        .RspValid(rsp_valid),
        .RspReady(rsp_ready),
        .RspData (rsp_data),
        .RspErr  (rsp_err),
        .Timeout (tmo),
        .CYC     (cyc),
        .STB     (stb),
        .WE      (we),
        .ADR     (adr),
        .DAT_O   (dat_o),
        .DAT_I   (dat_i),
        .ACK     (ack),
        .ERR     (err),
        .STALL   (stall)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [15:0] a,
                       input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_data = '0;
        rsp_ready = 0; dat_i = '0; ack = 0; err = 0; stall = 0;
        step();
        step();
        chk("rst_cyc", 16'(cyc), 16'd0);
        chk("rst_stb", 16'(stb), 16'd0);
        chk("rst_rspv", 16'(rsp_valid), 16'd0);
        chk("rst_rdy", 16'(cmd_ready), 16'd0);
        chk("rst_adr", adr, 16'h0000);
        chk("rst_dat", 16'(dat_o), 16'h0000);
        chk("rst_tmo", 16'(tmo), 16'd0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 16'(cmd_ready), 16'd1);

        // single read, ACK two cycles after the strobe
        cmd(1'b0, 16'hC000, 8'h00);
        step();
        cmd_valid = 1'b0;
        chk("rd_stb", 16'(stb), 16'd1);
        chk("rd_cyc", 16'(cyc), 16'd1);
        chk("rd_adr", adr, 16'hC000);
        chk("rd_we", 16'(we), 16'd0);
        step();
        chk("rd_stb_1cyc", 16'(stb), 16'd0);
        chk("rd_cyc_hold", 16'(cyc), 16'd1);
        step();
        ack = 1'b1; dat_i = 8'h5A;
        chk("rd_stb_off", 16'(stb), 16'd0);
        chk("rd_norsp_yet", 16'(rsp_valid), 16'd0);
        step();
        ack = 1'b0;
        chk("rd_cyc_drop", 16'(cyc), 16'd0);
        chk("rd_rspv", 16'(rsp_valid), 16'd1);
        chk("rd_data", 16'(rsp_data), 16'h005A);
        chk("rd_err", 16'(rsp_err), 16'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rd_popped", 16'(rsp_valid), 16'd0);

        // two back-to-back writes, credits exhausted
        cmd(1'b1, 16'hFF40, 8'h91);
        step();
        chk("w1_stb", 16'(stb), 16'd1);
        chk("w1_adr", adr, 16'hFF40);
        chk("w1_dat", 16'(dat_o), 16'h0091);
        chk("w1_we", 16'(we), 16'd1);
        cmd(1'b1, 16'hFF47, 8'hFC);
        #1;
        chk("w2_rdy", 16'(cmd_ready), 16'd1);
        step();
        chk("w2_stb", 16'(stb), 16'd1);
        chk("w2_adr", adr, 16'hFF47);
        chk("w2_dat", 16'(dat_o), 16'h00FC);
        cmd(1'b0, 16'h8000, 8'h00);
        #1;
        chk("w3_blocked", 16'(cmd_ready), 16'd0);
        step();
        chk("w3_no_stb", 16'(stb), 16'd0);
        chk("w3_blocked2", 16'(cmd_ready), 16'd0);
        ack = 1'b1;
        step();
        chk("w_cyc_mid", 16'(cyc), 16'd1);
        chk("w_rsp1", 16'(rsp_valid), 16'd1);
        chk("w_blocked3", 16'(cmd_ready), 16'd0);
        step();
        ack = 1'b0;
        cmd_valid = 1'b0;
        chk("w_cyc_drop", 16'(cyc), 16'd0);
        chk("w_rsp_err", 16'(rsp_err), 16'd0);
        rsp_ready = 1'b1;
        step();
        chk("w_rdy_after_pop", 16'(cmd_ready), 16'd1);
        chk("w_rsp2", 16'(rsp_valid), 16'd1);
        step();
        rsp_ready = 1'b0;
        chk("w_rsp_empty", 16'(rsp_valid), 16'd0);

        // stalled read; early ACK during stall must be ignored
        stall = 1'b1;
        cmd(1'b0, 16'h4000, 8'h00);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st_stb", 16'(stb), 16'd1);
            chk("st_adr", adr, 16'h4000);
            chk("st_we", 16'(we), 16'd0);
            if (i == 1) begin
                chk("st_rdy", 16'(cmd_ready), 16'd0);
                ack = 1'b1; dat_i = 8'hEE;
            end else begin
                ack = 1'b0;
            end
            step();
        end
        chk("st_no_rsp", 16'(rsp_valid), 16'd0);
        stall = 1'b0;
        chk("st_stb4", 16'(stb), 16'd1);
        chk("st_adr4", adr, 16'h4000);
        step();
        chk("st_stb_off", 16'(stb), 16'd0);
        chk("st_cyc", 16'(cyc), 16'd1);
        ack = 1'b1; dat_i = 8'h3C;
        step();
        ack = 1'b0;
        chk("st_cyc_drop", 16'(cyc), 16'd0);
        chk("st_data", 16'(rsp_data), 16'h003C);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("st_single", 16'(rsp_valid), 16'd0);

        // ERR on write (ERR wins over simultaneous ACK), then normal read
        cmd(1'b1, 16'hA000, 8'h12);
        step();
        cmd_valid = 1'b0;
        step();
        err = 1'b1; ack = 1'b1; dat_i = 8'h00;
        step();
        err = 1'b0; ack = 1'b0;
        chk("er_cyc", 16'(cyc), 16'd0);
        chk("er_rspv", 16'(rsp_valid), 16'd1);
        chk("er_err", 16'(rsp_err), 16'd1);
        rsp_ready = 1'b1;
        cmd(1'b0, 16'h0100, 8'h00);
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("er_next_stb", 16'(stb), 16'd1);
        chk("er_next_adr", adr, 16'h0100);
        step();
        ack = 1'b1; dat_i = 8'h77;
        step();
        ack = 1'b0;
        chk("er_next_data", 16'(rsp_data), 16'h0077);
        chk("er_next_err", 16'(rsp_err), 16'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // timeout with two reads outstanding
        cmd(1'b0, 16'h1000, 8'h00);
        step();
        cmd(1'b0, 16'h1001, 8'h00);
        step();
        cmd_valid = 1'b0;
        chk("to_stb2_adr", adr, 16'h1001);
        step();
        for (int i = 0; i < 16; i++) begin
            chk("to_silent_tmo", 16'(tmo), 16'd0);
            chk("to_silent_cyc", 16'(cyc), 16'd1);
            step();
        end
        chk("to_pulse", 16'(tmo), 16'd1);
        chk("to_cyc", 16'(cyc), 16'd0);
        chk("to_stb", 16'(stb), 16'd0);
        chk("to_rdy", 16'(cmd_ready), 16'd0);
        step();
        chk("to_pulse_end", 16'(tmo), 16'd0);
        chk("to_rspv", 16'(rsp_valid), 16'd1);
        step();
        ack = 1'b1; dat_i = 8'h42;
        chk("to_idle_cyc", 16'(cyc), 16'd0);
        step();
        ack = 1'b0;
        chk("to_late_cyc", 16'(cyc), 16'd0);
        chk("to_r1_data", 16'(rsp_data), 16'h00FF);
        chk("to_r1_err", 16'(rsp_err), 16'd1);
        rsp_ready = 1'b1;
        step();
        chk("to_r2_valid", 16'(rsp_valid), 16'd1);
        chk("to_r2_data", 16'(rsp_data), 16'h00FF);
        chk("to_r2_err", 16'(rsp_err), 16'd1);
        step();
        rsp_ready = 1'b0;
        chk("to_late_ignored", 16'(rsp_valid), 16'd0);
        chk("to_rdy_back", 16'(cmd_ready), 16'd1);

        // reset with one buffered response and one transfer in flight
        cmd(1'b0, 16'h2000, 8'h00);
        step();
        cmd_valid = 1'b0;
        step();
        ack = 1'b1; dat_i = 8'h11;
        step();
        ack = 1'b0;
        chk("rs_buffered", 16'(rsp_valid), 16'd1);
        cmd(1'b1, 16'h2001, 8'h55);
        step();
        cmd_valid = 1'b0;
        step();
        chk("rs_inflight", 16'(cyc), 16'd1);
        rst = 1'b1;
        step();
        chk("rs_cyc", 16'(cyc), 16'd0);
        chk("rs_stb", 16'(stb), 16'd0);
        chk("rs_we", 16'(we), 16'd0);
        chk("rs_adr", adr, 16'h0000);
        chk("rs_dat", 16'(dat_o), 16'h0000);
        chk("rs_rspv", 16'(rsp_valid), 16'd0);
        chk("rs_rdy", 16'(cmd_ready), 16'd0);
        rst = 1'b0;
        #1;
        chk("rs_rdy_after", 16'(cmd_ready), 16'd1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("rs_ack_ignored", 16'(rsp_valid), 16'd0);
        chk("rs_idle", 16'(cyc), 16'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/gbc_bus_initiator.md
Name: gbc_bus_initiator

Overview:
- Wishbone B4 pipelined initiator for the 16-bit-address / 8-bit-data Game Boy system bus. It is the counterpart of the bus-target port that the memory bus exposes to its master.
- Converts a simple command stream (valid/ready) from a CPU core or a debug/host bridge into Wishbone cycles.
- Tracks outstanding transfers and returns in-order responses through a buffered response stream.
- Provides a bus timeout so a hung target (stalled mapper, missing device) cannot lock the master.

Parameters:
- MaxOutstanding, 2: maximum commands issued but not yet popped as responses (1..4). This also sets the response FIFO depth.
- TimeoutCycles, 1024: CYC-active cycles with no strobe acceptance and no ACK/ERR before abort (≥2).
- TimeoutData, 8'hFF: RspData returned for aborted transfers.

Ports:
- CLK  in  1  system clock (the SysCon.CLK of the ISysCon bundle).
- RST  in  1  synchronous, active-high reset (the SysCon.RST of the ISysCon bundle).
- CmdValid  in  1  command present.
- CmdReady  out  1  command accepted when CmdValid & CmdReady.
- CmdWrite  in  1  1 = write, 0 = read.
- CmdAddr  in  16  bus address.
- CmdData  in  8  write data.
- RspValid  out  1  response available.
- RspReady  in  1  response consumed when RspValid & RspReady.
- RspData  out  8  read data. Undefined-but-stable for writes; TimeoutData on abort.
- RspErr  out  1  1 = target ERR or timeout abort.
- Timeout  out  1  one-cycle pulse on entry to ABORT.
- CYC  out  1  Wishbone cycle.
- STB  out  1  Wishbone strobe.
- WE  out  1  Wishbone write enable.
- ADR  out  16  Wishbone address.
- DAT_O  out  8  Wishbone write data.
- DAT_I  in  8  Wishbone read data.
- ACK  in  1  Wishbone acknowledge.
- ERR  in  1  Wishbone error.
- STALL  in  1  Wishbone pipeline stall.

Behaviour:
- Reset (RST=1 on a CLK edge):
  - CYC, STB, WE, RspValid, Timeout, CmdReady = 0; ADR = 0; DAT_O = 0.
  - Outstanding count, credit count, FIFO pointers and timeout counter = 0.
  - State = IDLE. Reset mid-operation drops all in-flight transfers and buffered responses; no responses are produced for them.
- Credits:
  - credits = commands accepted − responses popped; always ≤ MaxOutstanding.
  - CmdReady = (state ≠ ABORT) & (credits < MaxOutstanding) & (~STB | ~STALL). It is combinational from registered state plus STALL.
- Issue:
  - A command accepted at edge N drives STB=1, CYC=1 and ADR/WE/DAT_O from the command after edge N (registered, 1-cycle latency).
  - While STB & STALL, ADR/WE/DAT_O/STB are held stable.
  - The strobe is accepted on STB & ~STALL, and outstanding increments.
  - If a new command is accepted in the same cycle the strobe is accepted, STB stays 1 with the new fields (back-to-back, one transfer per cycle).
- Completion:
  - ACK or ERR while outstanding > 0 decrements outstanding and pushes {DAT_I, ERR} into the response FIFO. ERR takes priority if both are asserted.
  - ACK/ERR while outstanding == 0 is ignored; this includes an ACK in the same cycle as the first strobe acceptance.
  - Simultaneous strobe accept and ACK leaves outstanding unchanged.
- CYC:
  - CYC = 1 whenever STB = 1 or outstanding > 0.
  - CYC drops in the cycle after the final ACK/ERR if no new strobe is pending.
  - CYC is never deasserted with outstanding > 0 except in ABORT.
- Response FIFO:
  - Depth MaxOutstanding, first-word-fall-through; RspValid = not empty.
  - Push and pop in the same cycle are both honoured. It cannot overflow, by credit construction.
- States:
  - IDLE: CYC = 0. Moves to BUSY on command accept.
  - BUSY: CYC = 1. Moves to IDLE when STB = 0 and outstanding reaches 0.
  - Moves to ABORT when the timeout counter reaches TimeoutCycles − 1. The counter clears on any strobe acceptance or ACK/ERR, counts every BUSY cycle otherwise, and is held at 0 in IDLE.
  - ABORT:
    - CYC = STB = 0 immediately; Timeout pulses for one cycle.
    - One error response {TimeoutData, 1} is pushed per cycle for each outstanding transfer, plus one for an unaccepted pending strobe.
    - Bus inputs are ignored.
    - Returns to IDLE when the error count is exhausted. With zero outstanding and no pending strobe, ABORT lasts 1 cycle.

Test Plan:
- Single read, addr 0xC000, target ACKs 2 cycles after strobe with DAT_I = 0x5A → STB high for exactly 1 cycle; CYC drops the cycle after ACK; response {0x5A, 0} with RspValid 1 cycle after ACK.
- Two back-to-back writes (0xFF40←0x91, 0xFF47←0xFC), MaxOutstanding = 2, STALL = 0 → STB high 2 consecutive cycles with the correct ADR/DAT_O; CmdReady = 0 for a third command until a response is popped.
- STALL held 3 cycles on a read of 0x4000 → ADR/WE/STB stable for 4 cycles; outstanding increments only on the ~STALL cycle; a single response is returned.
- Target returns ERR on a write to 0xA000 → response RspErr = 1; CYC drops; the next command issues normally.
- No ACK, TimeoutCycles = 16, 2 reads outstanding → Timeout pulses on cycle 16 of silence; CYC = 0; two responses {0xFF, 1} in order; a late ACK afterwards is ignored.
- Reset asserted with 1 transfer outstanding and 1 buffered response → next cycle all outputs at reset values, RspValid = 0, CmdReady = 1 in the cycle after reset deasserts.
